// File: rtl/ml_accel_pkg.sv
// Shared constants and writeback FSM encoding for the systolic accelerator output path.
package ml_accel_pkg;

    localparam int unsigned ARRAY_SIZE = 16;
    localparam int unsigned PSUM_W     = 24;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_row_fifo.sv
// Synchronous row FIFO with registered full/empty; a pop frees its slot one cycle later.
module wb_row_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 384
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push   = push && !full_q;
    assign do_pop    = pop && !empty_q;
    assign head_data = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (PtrW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ml_result_writeback.sv
// Psum row writer: buffers array output rows and writes valid elements as 32-bit words.
// Build option WB_RELU_EN: negative elements are written as zero instead of sign-extended.
module ml_result_writeback #(
    parameter int unsigned ARRAY_SIZE    = 16,
    parameter int unsigned PSUM_W        = 24,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned ROW_BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            cfg_base_addr,
    input  logic [31:0]                  cfg_row_stride,
    input  logic [31:0]                  cfg_m_size,
    input  logic [31:0]                  cfg_n_size,
    input  logic [15:0]                  cfg_tile_row,
    input  logic [15:0]                  cfg_tile_col,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    input  logic [ARRAY_SIZE*PSUM_W-1:0] flat_psum_in,
    output logic [ADDR_W-1:0]            mem_write_addr,
    output logic [31:0]                  mem_write_data,
    output logic                         mem_write_en,
    input  logic                         mem_write_ready,
    output logic                         busy,
    output logic                         irq_done,
    output logic [31:0]                  words_written
);

    import ml_accel_pkg::*;

    localparam int unsigned CntW = $clog2(ARRAY_SIZE + 1);
    localparam int unsigned ColW = $clog2(ARRAY_SIZE);

    wb_state_e                  state_q, state_d;
    logic [ADDR_W-1:0]          base_q;
    logic [31:0]                stride_q, m_q, n_q, words_q;
    logic [15:0]                tile_row_q, tile_col_q;
    logic [CntW-1:0]            rows_acc_q, rows_done_q;
    logic [ColW-1:0]            col_q;

    logic [ARRAY_SIZE*PSUM_W-1:0] head_row;
    logic                         fifo_full, fifo_empty;
    logic                         run, accept, draining, pad, wr_en, step, last_col, pop;
    logic [31:0]                  gr, gc;
    logic [PSUM_W-1:0]            elem;
    logic [31:0]                  elem_word;
    logic [ADDR_W-1:0]            addr_calc;

    wb_row_fifo #(
        .DEPTH (ROW_BUF_DEPTH),
        .WIDTH (ARRAY_SIZE*PSUM_W)
    ) u_row_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (flat_psum_in),
        .pop       (pop),
        .head_data (head_row),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign run        = (state_q == StRun);
    assign psum_ready = run && !fifo_full && (rows_acc_q < CntW'(ARRAY_SIZE));
    assign accept     = psum_valid && psum_ready;
    assign draining   = run && !fifo_empty;

    // Head row index equals rows already popped this tile.
    assign gr  = {16'b0, tile_row_q} * 32'(ARRAY_SIZE) + 32'(rows_done_q);
    assign gc  = {16'b0, tile_col_q} * 32'(ARRAY_SIZE) + 32'(col_q);
    assign pad = (gr >= m_q) || (gc >= n_q);

    assign wr_en    = draining && !pad;
    assign step     = draining && (pad || mem_write_ready);
    assign last_col = (col_q == ColW'(ARRAY_SIZE - 1));
    assign pop      = step && last_col;

    assign elem      = head_row[col_q*PSUM_W +: PSUM_W];
    assign addr_calc = base_q + ADDR_W'(gr * stride_q) + ADDR_W'(gc << 2);

`ifdef WB_RELU_EN
    assign elem_word = elem[PSUM_W-1] ? 32'h0 : 32'(signed'(elem));
`else
    assign elem_word = 32'(signed'(elem));
`endif

    assign mem_write_en   = wr_en;
    assign mem_write_addr = wr_en ? addr_calc : '0;
    assign mem_write_data = wr_en ? elem_word : '0;
    assign busy           = run;
    assign irq_done       = (state_q == StDone);
    assign words_written  = words_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (pop && (rows_done_q == CntW'(ARRAY_SIZE - 1))) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            stride_q    <= '0;
            m_q         <= '0;
            n_q         <= '0;
            tile_row_q  <= '0;
            tile_col_q  <= '0;
            rows_acc_q  <= '0;
            rows_done_q <= '0;
            col_q       <= '0;
            words_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                base_q      <= cfg_base_addr;
                stride_q    <= cfg_row_stride;
                m_q         <= cfg_m_size;
                n_q         <= cfg_n_size;
                tile_row_q  <= cfg_tile_row;
                tile_col_q  <= cfg_tile_col;
                rows_acc_q  <= '0;
                rows_done_q <= '0;
                col_q       <= '0;
                words_q     <= '0;
            end else begin
                if (accept) rows_acc_q <= rows_acc_q + 1'b1;
                if (step)   col_q <= last_col ? '0 : col_q + 1'b1;
                if (pop)    rows_done_q <= rows_done_q + 1'b1;
                if (wr_en && mem_write_ready) words_q <= words_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ml_result_writeback.sv
// Scoreboard bench for ml_result_writeback: expected writes queued per accepted row.
module tb_ml_result_writeback;

    localparam int AS = 16;
    localparam int PW = 24;
    localparam int AW = 32;
    localparam int DEPTH = 4;

    logic              clk, rst_n, start;
    logic [AW-1:0]     cfg_base_addr;
    logic [31:0]       cfg_row_stride, cfg_m_size, cfg_n_size;
    logic [15:0]       cfg_tile_row, cfg_tile_col;
    logic              psum_valid, psum_ready;
    logic [AS*PW-1:0]  flat_psum_in;
    logic [AW-1:0]     mem_write_addr;
    logic [31:0]       mem_write_data;
    logic              mem_write_en, mem_write_ready, busy, irq_done;
    logic [31:0]       words_written;

    ml_result_writeback #(
        .ARRAY_SIZE    (AS),
        .PSUM_W        (PW),
        .ADDR_W        (AW),
        .ROW_BUF_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_row_stride  (cfg_row_stride),
        .cfg_m_size      (cfg_m_size),
        .cfg_n_size      (cfg_n_size),
        .cfg_tile_row    (cfg_tile_row),
        .cfg_tile_col    (cfg_tile_col),
        .psum_valid      (psum_valid),
        .psum_ready      (psum_ready),
        .flat_psum_in    (flat_psum_in),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_write_ready (mem_write_ready),
        .busy            (busy),
        .irq_done        (irq_done),
        .words_written   (words_written)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_writes, rows_sent, rows_at_stall, ready_mode, cyc;
    bit          stall_seen, abort, seen_1048;
    logic [31:0] first_addr, data_1000, data_1004;
    logic [31:0] m_base, m_stride, m_m, m_n;
    logic [15:0] m_tr, m_tc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [PW-1:0] e);
`ifdef WB_RELU_EN
        if (e[PW-1]) return 32'h0;
`endif
        return {{(32-PW){e[PW-1]}}, e};
    endfunction

    // Memory-ready pattern: always, or one cycle in four.
    initial begin
        cyc = 0;
        mem_write_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_write_ready = (ready_mode == 0) || (cyc % 4 == 0);
        end
    end

    // Every cycle with en high must present the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(exp_q.size()), 1);
                end else begin
                    check("addr", mem_write_addr, exp_q[0].addr);
                    check("data", mem_write_data, exp_q[0].data);
                    if (mem_write_ready) begin
                        if (n_writes == 0) first_addr = mem_write_addr;
                        if (mem_write_addr == 32'h1000) data_1000 = mem_write_data;
                        if (mem_write_addr == 32'h1004) data_1004 = mem_write_data;
                        if (mem_write_addr == 32'h1048) seen_1048 = 1'b1;
                        n_writes++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (rst_n && busy && psum_valid && !psum_ready && !stall_seen) begin
                stall_seen    = 1'b1;
                rows_at_stall = rows_sent;
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input logic [31:0] stride,
                            input logic [31:0] m, input logic [31:0] n,
                            input logic [15:0] tr, input logic [15:0] tc);
        cfg_base_addr  = base;
        cfg_row_stride = stride;
        cfg_m_size     = m;
        cfg_n_size     = n;
        cfg_tile_row   = tr;
        cfg_tile_col   = tc;
        m_base = base; m_stride = stride; m_m = m; m_n = n; m_tr = tr; m_tc = tc;
        n_writes   = 0;
        rows_sent  = 0;
        stall_seen = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1);
    endtask

    task automatic send_rows();
        logic [AS*PW-1:0] row;
        logic [PW-1:0]    e;
        logic [31:0]      gr, gc;
        bit               acc;
        int               cnt;
        for (int r = 0; r < AS; r++) begin
            for (int c = 0; c < AS; c++) begin
                e = PW'($urandom);
                if (r == 0 && c == 0) e = 24'hFFFFF0;
                if (r == 0 && c == 1) e = 24'h00007F;
                row[c*PW +: PW] = e;
            end
            flat_psum_in = row;
            psum_valid   = 1'b1;
            acc = 1'b0;
            cnt = 0;
            while (!acc && !abort && cnt < 4000) begin
                @(negedge clk);
                acc = psum_ready;
                @(posedge clk);
                #1;
                cnt++;
            end
            if (abort) break;
            if (!acc) begin
                check("accept_timeout", acc, 1);
                break;
            end
            for (int c = 0; c < AS; c++) begin
                gr = 32'(m_tr) * 32'(AS) + 32'(r);
                gc = 32'(m_tc) * 32'(AS) + 32'(c);
                if (gr < m_m && gc < m_n)
                    exp_q.push_back('{addr: m_base + gr * m_stride + gc * 4,
                                      data: exp_data(row[c*PW +: PW])});
            end
            rows_sent++;
        end
        psum_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_words);
        int cnt = 0;
        while (!irq_done && cnt < 6000) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_irq"}, irq_done, 1);
        check({tag, "_words"}, words_written, 32'(exp_words));
        check({tag, "_nwrites"}, 32'(n_writes), 32'(exp_words));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
        @(negedge clk);
        check({tag, "_irq_pulse"}, irq_done, 0);
        check({tag, "_busy_clear"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, psum_ready, 0);
        check({tag, "_en"}, mem_write_en, 0);
        check({tag, "_addr"}, mem_write_addr, 0);
        check({tag, "_data"}, mem_write_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_irq"}, irq_done, 0);
        check({tag, "_words"}, words_written, 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; start = 1'b0; psum_valid = 1'b0; flat_psum_in = '0;
        cfg_base_addr = '0; cfg_row_stride = '0; cfg_m_size = '0; cfg_n_size = '0;
        cfg_tile_row = '0; cfg_tile_col = '0;
        ready_mode = 0; abort = 1'b0; seen_1048 = 1'b0;
        data_1000 = '0; data_1004 = '0; first_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full tile, memory always ready.
        do_start(32'h1000, 64, 16, 16, 0, 0);
        send_rows();
        wait_done("t1", 256);
        check("t1_addr_1048", seen_1048, 1);
`ifdef WB_RELU_EN
        check("t1_neg_elem", data_1000, 32'h0);
`else
        check("t1_neg_elem", data_1000, 32'hFFFFFFF0);
`endif
        check("t1_pos_elem", data_1004, 32'h7F);

        // Edge tile of a 20x20 result: only a 4x4 corner is real.
        do_start(32'h2000, 80, 20, 20, 1, 1);
        send_rows();
        wait_done("t2", 16);
        check("t2_first_addr", first_addr, 32'h2540);

        // Slow memory: buffer fills and backpressures the array.
        ready_mode = 1;
        do_start(32'h1000, 64, 16, 16, 0, 0);
        send_rows();
        wait_done("t3", 256);
        check("t3_stall_seen", stall_seen, 1);
        check("t3_rows_at_stall", 32'(rows_at_stall), 32'(DEPTH));
        ready_mode = 0;

        // Asynchronous reset in the middle of draining row 5.
        do_start(32'h1000, 64, 16, 16, 0, 0);
        fork
            send_rows();
            begin
                cnt = 0;
                while (n_writes < 5 * AS + 3 && cnt < 3000) begin
                    @(negedge clk);
                    cnt++;
                end
                check("t5_reach_row5", 32'(n_writes >= 5 * AS + 3), 1);
                #2;
                abort = 1'b1;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("t5_rst");
            end
        join
        exp_q.delete();
        @(posedge clk);
        #1;
        abort = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(32'h1000, 64, 16, 16, 0, 0);
        send_rows();
        wait_done("t5", 256);

        // Start while busy must not disturb the running tile.
        do_start(32'h3000, 64, 16, 16, 0, 0);
        fork
            send_rows();
            begin
                repeat (20) @(posedge clk);
                #1;
                cfg_base_addr  = 32'hDEAD0000;
                cfg_row_stride = 32'd4;
                cfg_m_size     = 32'd1;
                cfg_n_size     = 32'd1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("t6_still_busy", busy, 1);
            end
        join
        wait_done("t6", 256);

        // Empty matrix: every row is padding, irq still fires.
        do_start(32'h1000, 64, 0, 16, 0, 0);
        send_rows();
        wait_done("t6m0", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
